// File: rtl/zap_shift_operand_seq.sv
// zap_shift_operand_seq
// Resolves the shifter operand set (source, amount, carry, shift type) for a
// data-processing instruction. Immediate amounts are resolved on accept;
// register amounts are taken from Rs[7:0] once Rs data is valid.
// Optional build macro: ZAP_SHIFT_RS_FWD_EN -- when defined, a register shift
// whose Rs data is already valid on the accept cycle skips the Rs wait state.
//
// state   | meaning
// IDLE    | no operand held, ready for a request
// WAIT_RS | register shift accepted, waiting for Rs data
// OUT     | operand set presented to the shifter, held until i_ready
module zap_shift_operand_seq #(
  parameter int SHIFT_OPS = 5
) (
  input  logic                         i_clk,
  input  logic                         i_reset_n,
  input  logic                         i_clear,
  input  logic                         i_valid,
  output logic                         o_ready,
  input  logic [31:0]                  i_source,
  input  logic                         i_carry,
  input  logic [$clog2(SHIFT_OPS)-1:0] i_shift_type,
  input  logic                         i_amt_is_reg,
  input  logic [4:0]                   i_imm_amount,
  input  logic                         i_rs_valid,
  input  logic [31:0]                  i_rs_data,
  output logic                         o_valid,
  input  logic                         i_ready,
  output logic [31:0]                  o_source,
  output logic [7:0]                   o_amount,
  output logic                         o_carry,
  output logic [$clog2(SHIFT_OPS)-1:0] o_shift_type
);

  localparam int TW = $clog2(SHIFT_OPS);

  // Architectural types occupy the low encodings; RORI/RRC are the
  // shifter-only encodings produced by immediate ROR resolution.
  localparam logic [TW-1:0] LSL  = TW'(0);
  localparam logic [TW-1:0] LSR  = TW'(1);
  localparam logic [TW-1:0] ASR  = TW'(2);
  localparam logic [TW-1:0] ROR  = TW'(3);
  localparam logic [TW-1:0] RORI = TW'(4);
  localparam logic [TW-1:0] RRC  = TW'(5);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_WAIT_RS = 2'd1,
    S_OUT     = 2'd2
  } state_t;

  state_t           r_state;
  logic             r_valid;
  logic [31:0]      r_source;
  logic [7:0]       r_amount;
  logic             r_carry;
  logic [TW-1:0]    r_shift_type;

  logic             w_ready;
  logic             w_accept;
  logic             w_fwd;
  logic [TW-1:0]    w_imm_type;
  logic [7:0]       w_imm_amount;
  logic [TW-1:0]    w_reg_type;
  logic             w_unused;

  assign w_ready  = (r_state == S_IDLE) | ((r_state == S_OUT) & i_ready);
  assign w_accept = i_valid & w_ready;
  assign o_ready  = w_ready;

  // Register shifts carry the architectural type straight through.
  assign w_reg_type = TW'({1'b0, i_shift_type[1:0]});

  // Only the low byte of Rs is a shift amount.
  assign w_unused = ^i_rs_data[31:8];

`ifdef ZAP_SHIFT_RS_FWD_EN
  assign w_fwd = i_rs_valid;
`else
  assign w_fwd = 1'b0;
`endif

  // Immediate amount remapping: #0 means 32 for LSR/ASR and RRX for ROR.
  always_comb begin
    w_imm_type   = i_shift_type;
    w_imm_amount = {3'b000, i_imm_amount};
    case (i_shift_type)
      LSR, ASR: begin
        if (i_imm_amount == 5'd0) w_imm_amount = 8'd32;
      end
      ROR: begin
        if (i_imm_amount == 5'd0) w_imm_type = RRC;
        else                      w_imm_type = RORI;
      end
      default: ;
    endcase
  end

  // Sequencer FSM with registered operand outputs.
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_state      <= S_IDLE;
      r_valid      <= 1'b0;
      r_source     <= 32'd0;
      r_amount     <= 8'd0;
      r_carry      <= 1'b0;
      r_shift_type <= '0;
    end else if (i_clear) begin
      r_state <= S_IDLE;
      r_valid <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE, S_OUT: begin
          if (w_accept) begin
            r_source <= i_source;
            r_carry  <= i_carry;
            if (!i_amt_is_reg) begin
              r_shift_type <= w_imm_type;
              r_amount     <= w_imm_amount;
              r_state      <= S_OUT;
              r_valid      <= 1'b1;
            end else if (w_fwd) begin
              r_shift_type <= w_reg_type;
              r_amount     <= i_rs_data[7:0];
              r_state      <= S_OUT;
              r_valid      <= 1'b1;
            end else begin
              r_shift_type <= w_reg_type;
              r_state      <= S_WAIT_RS;
              r_valid      <= 1'b0;
            end
          end else if ((r_state == S_OUT) && i_ready) begin
            r_state <= S_IDLE;
            r_valid <= 1'b0;
          end
        end
        S_WAIT_RS: begin
          if (i_rs_valid) begin
            r_amount <= i_rs_data[7:0];
            r_state  <= S_OUT;
            r_valid  <= 1'b1;
          end
        end
        default: begin
          r_state <= S_IDLE;
          r_valid <= 1'b0;
        end
      endcase
    end
  end

  assign o_valid      = r_valid;
  assign o_source     = r_source;
  assign o_amount     = r_amount;
  assign o_carry      = r_carry;
  assign o_shift_type = r_shift_type;

endmodule

// File: tb/tb_zap_shift_operand_seq.sv
// Testbench for zap_shift_operand_seq. Expected operand sets are queued when a
// request is driven and compared when the shifter-side handshake completes.
module tb_zap_shift_operand_seq;

  localparam logic [2:0] T_LSL  = 3'd0;
  localparam logic [2:0] T_LSR  = 3'd1;
  localparam logic [2:0] T_ASR  = 3'd2;
  localparam logic [2:0] T_ROR  = 3'd3;
  localparam logic [2:0] T_RORI = 3'd4;
  localparam logic [2:0] T_RRC  = 3'd5;

  typedef struct packed {
    logic [31:0] src;
    logic [7:0]  amt;
    logic        c;
    logic [2:0]  t;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        clear, valid, carry, is_reg, rs_valid, ready;
  logic [31:0] source, rs_data;
  logic [2:0]  stype;
  logic [4:0]  imm;
  logic        o_ready, o_valid, o_carry;
  logic [31:0] o_source;
  logic [7:0]  o_amount;
  logic [2:0]  o_shift_type;

  int   errors = 0;
  int   checks = 0;
  exp_t sb[$];
  exp_t e;

  always #5 clk = ~clk;

  zap_shift_operand_seq #(.SHIFT_OPS(5)) dut (
    .i_clk        (clk),
    .i_reset_n    (rst_n),
    .i_clear      (clear),
    .i_valid      (valid),
    .o_ready      (o_ready),
    .i_source     (source),
    .i_carry      (carry),
    .i_shift_type (stype),
    .i_amt_is_reg (is_reg),
    .i_imm_amount (imm),
    .i_rs_valid   (rs_valid),
    .i_rs_data    (rs_data),
    .o_valid      (o_valid),
    .i_ready      (ready),
    .o_source     (o_source),
    .o_amount     (o_amount),
    .o_carry      (o_carry),
    .o_shift_type (o_shift_type)
  );

  // Shifter-side monitor: every completed handshake must match the queue head.
  always @(negedge clk) begin
    if (rst_n && o_valid && ready) begin
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL sb_unexpected: got src=%h amt=%h c=%b t=%0d, want no output",
                 o_source, o_amount, o_carry, o_shift_type);
      end else begin
        e = sb.pop_front();
        if ({o_source, o_amount, o_carry, o_shift_type} !== e) begin
          errors++;
          $display("FAIL sb_operand: got src=%h amt=%h c=%b t=%0d, want src=%h amt=%h c=%b t=%0d",
                   o_source, o_amount, o_carry, o_shift_type, e.src, e.amt, e.c, e.t);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic drive_idle();
    valid = 1'b0; is_reg = 1'b0; rs_valid = 1'b0; clear = 1'b0;
  endtask

  task automatic drive_req(input logic [31:0] s, input logic c, input logic [2:0] t,
                           input logic r, input logic [4:0] n);
    valid = 1'b1; source = s; carry = c; stype = t; is_reg = r; imm = n;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; ready = 1'b1; source = 32'd0; carry = 1'b0; stype = 3'd0;
    imm = 5'd0; rs_data = 32'd0;
    drive_idle();
    #1;
    checks++;
    if (o_valid !== 1'b0 || o_ready !== 1'b1) begin
      errors++; $display("FAIL reset_ctrl: got valid=%b ready=%b, want 0/1", o_valid, o_ready);
    end
    checks++;
    if ({o_source, o_amount, o_carry, o_shift_type} !== 44'd0) begin
      errors++; $display("FAIL reset_data: got src=%h amt=%h c=%b t=%0d, want all 0",
                         o_source, o_amount, o_carry, o_shift_type);
    end
    tick(); tick();
    rst_n = 1'b1;
  endtask

  task automatic test_imm_lsr0();
    tick();
    drive_req(32'h8000_0000, 1'b0, T_LSR, 1'b0, 5'd0);
    sb.push_back('{32'h8000_0000, 8'd32, 1'b0, T_LSR});
    #1;
    checks++;
    if (o_ready !== 1'b1) begin errors++; $display("FAIL lsr0_ready: got %b want 1", o_ready); end
    tick();
    drive_idle();
    #1;
    checks++;
    if (o_valid !== 1'b1 || o_amount !== 8'd32 || o_shift_type !== T_LSR) begin
      errors++; $display("FAIL lsr0_latency: got valid=%b amt=%0d t=%0d, want 1/32/%0d",
                         o_valid, o_amount, o_shift_type, T_LSR);
    end
    tick();
    #1;
    checks++;
    if (o_valid !== 1'b0) begin errors++; $display("FAIL lsr0_drop: got valid=%b want 0", o_valid); end
  endtask

  task automatic test_back_to_back();
    tick();
    drive_req(32'hA5A5_0001, 1'b1, T_ROR, 1'b0, 5'd0);
    sb.push_back('{32'hA5A5_0001, 8'd0, 1'b1, T_RRC});
    tick();
    drive_req(32'h1234_5678, 1'b0, T_ROR, 1'b0, 5'd4);
    sb.push_back('{32'h1234_5678, 8'd4, 1'b0, T_RORI});
    #1;
    checks++;
    if (o_ready !== 1'b1 || o_valid !== 1'b1 || o_shift_type !== T_RRC || o_amount !== 8'd0) begin
      errors++; $display("FAIL b2b_first: got rdy=%b valid=%b t=%0d amt=%0d, want 1/1/%0d/0",
                         o_ready, o_valid, o_shift_type, o_amount, T_RRC);
    end
    tick();
    drive_idle();
    #1;
    checks++;
    if (o_valid !== 1'b1 || o_shift_type !== T_RORI || o_amount !== 8'd4) begin
      errors++; $display("FAIL b2b_second: got valid=%b t=%0d amt=%0d, want 1/%0d/4",
                         o_valid, o_shift_type, o_amount, T_RORI);
    end
    tick();
  endtask

  task automatic test_reg_asr();
    tick();
    drive_req(32'hF000_000F, 1'b0, T_ASR, 1'b1, 5'd9);
    sb.push_back('{32'hF000_000F, 8'h21, 1'b0, T_ASR});
    tick();
    drive_idle();
    for (int i = 0; i < 3; i++) begin
      #1;
      checks++;
      if (o_ready !== 1'b0 || o_valid !== 1'b0) begin
        errors++; $display("FAIL reg_wait%0d: got rdy=%b valid=%b, want 0/0", i, o_ready, o_valid);
      end
      tick();
    end
    rs_valid = 1'b1; rs_data = 32'h0000_0121;
    #1;
    checks++;
    if (o_ready !== 1'b0) begin errors++; $display("FAIL reg_wait_rs: got rdy=%b want 0", o_ready); end
    tick();
    rs_valid = 1'b0;
    #1;
    checks++;
    if (o_valid !== 1'b1 || o_amount !== 8'h21 || o_shift_type !== T_ASR) begin
      errors++; $display("FAIL reg_out: got valid=%b amt=%h t=%0d, want 1/21/%0d",
                         o_valid, o_amount, o_shift_type, T_ASR);
    end
    tick();
  endtask

  task automatic test_backpressure();
    tick();
    drive_req(32'hDEAD_0003, 1'b1, T_LSL, 1'b0, 5'd3);
    sb.push_back('{32'hDEAD_0003, 8'd3, 1'b1, T_LSL});
    tick();
    drive_req(32'hBEEF_0007, 1'b0, T_LSR, 1'b0, 5'd7);
    sb.push_back('{32'hBEEF_0007, 8'd7, 1'b0, T_LSR});
    ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      #1;
      checks++;
      if (o_ready !== 1'b0 || o_valid !== 1'b1 || o_amount !== 8'd3 || o_source !== 32'hDEAD_0003) begin
        errors++; $display("FAIL bp_hold%0d: got rdy=%b valid=%b amt=%0d src=%h, want 0/1/3/dead0003",
                           i, o_ready, o_valid, o_amount, o_source);
      end
      tick();
    end
    ready = 1'b1;
    #1;
    checks++;
    if (o_ready !== 1'b1) begin errors++; $display("FAIL bp_release: got rdy=%b want 1", o_ready); end
    tick();
    drive_idle();
    #1;
    checks++;
    if (o_valid !== 1'b1 || o_amount !== 8'd7 || o_source !== 32'hBEEF_0007) begin
      errors++; $display("FAIL bp_next: got valid=%b amt=%0d src=%h, want 1/7/beef0007",
                         o_valid, o_amount, o_source);
    end
    tick();
  endtask

  task automatic test_rs_fwd();
    tick();
    drive_req(32'h0000_00C3, 1'b1, T_LSL, 1'b1, 5'd0);
    rs_valid = 1'b1; rs_data = 32'h0000_00FF;
    sb.push_back('{32'h0000_00C3, 8'hFF, 1'b1, T_LSL});
    tick();
    valid = 1'b0;
`ifdef ZAP_SHIFT_RS_FWD_EN
    rs_valid = 1'b0;
    #1;
    checks++;
    if (o_valid !== 1'b1 || o_amount !== 8'hFF) begin
      errors++; $display("FAIL fwd_latency: got valid=%b amt=%h, want 1/ff", o_valid, o_amount);
    end
`else
    #1;
    checks++;
    if (o_valid !== 1'b0) begin
      errors++; $display("FAIL nofwd_wait: got valid=%b want 0", o_valid);
    end
    tick();
    rs_valid = 1'b0;
    #1;
    checks++;
    if (o_valid !== 1'b1 || o_amount !== 8'hFF) begin
      errors++; $display("FAIL nofwd_latency: got valid=%b amt=%h, want 1/ff", o_valid, o_amount);
    end
`endif
    tick();
    drive_idle();
  endtask

  task automatic test_clear();
    tick();
    drive_req(32'h0BAD_0001, 1'b0, T_ROR, 1'b1, 5'd0);
    tick();
    valid = 1'b0; clear = 1'b1; rs_valid = 1'b1; rs_data = 32'h0000_0005;
    tick();
    drive_idle();
    #1;
    checks++;
    if (o_valid !== 1'b0 || o_ready !== 1'b1) begin
      errors++; $display("FAIL clr_wait: got valid=%b rdy=%b, want 0/1", o_valid, o_ready);
    end
    tick();
    drive_req(32'h6666_0001, 1'b0, T_LSL, 1'b0, 5'd1);
    sb.push_back('{32'h6666_0001, 8'd1, 1'b0, T_LSL});
    tick();
    drive_req(32'h0BAD_0002, 1'b1, T_LSL, 1'b0, 5'd2);
    clear = 1'b1;
    tick();
    drive_idle();
    #1;
    checks++;
    if (o_valid !== 1'b0 || o_ready !== 1'b1) begin
      errors++; $display("FAIL clr_out: got valid=%b rdy=%b, want 0/1", o_valid, o_ready);
    end
    tick();
    checks++;
    if (o_valid !== 1'b0) begin errors++; $display("FAIL clr_drop: got valid=%b want 0", o_valid); end
    drive_req(32'h7777_0005, 1'b1, T_LSR, 1'b0, 5'd5);
    sb.push_back('{32'h7777_0005, 8'd5, 1'b1, T_LSR});
    tick();
    drive_idle();
    #1;
    checks++;
    if (o_valid !== 1'b1 || o_amount !== 8'd5) begin
      errors++; $display("FAIL clr_after: got valid=%b amt=%0d, want 1/5", o_valid, o_amount);
    end
    tick();
  endtask

  task automatic test_async_reset();
    tick();
    drive_req(32'h1111_2222, 1'b1, T_ASR, 1'b1, 5'd0);
    tick();
    drive_idle();
    rst_n = 1'b0;
    #1;
    checks++;
    if (o_ready !== 1'b1 || o_valid !== 1'b0 || o_source !== 32'd0) begin
      errors++; $display("FAIL rst_wait: got rdy=%b valid=%b src=%h, want 1/0/0", o_ready, o_valid, o_source);
    end
    tick();
    rst_n = 1'b1;
    tick();
    drive_req(32'h3333_4444, 1'b1, T_LSL, 1'b0, 5'd6);
    ready = 1'b0;
    tick();
    drive_idle();
    rst_n = 1'b0;
    #1;
    checks++;
    if (o_valid !== 1'b0 || o_amount !== 8'd0 || o_source !== 32'd0) begin
      errors++; $display("FAIL rst_out: got valid=%b amt=%0d src=%h, want 0/0/0", o_valid, o_amount, o_source);
    end
    tick();
    rst_n = 1'b1; ready = 1'b1;
    tick();
  endtask

  initial begin
    test_reset();
    test_imm_lsr0();
    test_back_to_back();
    test_reg_asr();
    test_backpressure();
    test_rs_fwd();
    test_clear();
    test_async_reset();
    tick(); tick();
    checks++;
    if (sb.size() != 0) begin
      errors++; $display("FAIL sb_leftover: got %0d pending, want 0", sb.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
